// File: rtl/scr1_imem_arb_pkg.sv
// Shared types for the SCR1 instruction-memory arbiter: owner encoding and
// imem response codes.
package scr1_imem_arb_pkg;

   typedef enum logic {
      CORE = 1'b0,
      AUX  = 1'b1
   } type_scr1_imem_arb_owner_e;

   localparam logic [1:0] SCR1_MEM_RESP_NOTRDY = 2'b00;
   localparam logic [1:0] SCR1_MEM_RESP_RDY_OK = 2'b01;
   localparam logic [1:0] SCR1_MEM_RESP_RDY_ER = 2'b10;

endpackage : scr1_imem_arb_pkg

// File: rtl/scr1_imem_arb_owner_fifo.sv
// In-order owner FIFO: remembers which requester owns each outstanding imem
// transfer. DEPTH must be a power of two so the pointers wrap naturally.
module scr1_imem_arb_owner_fifo
   import scr1_imem_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  type_scr1_imem_arb_owner_e  din_i,
   output type_scr1_imem_arb_owner_e  dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     cnt_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   type_scr1_imem_arb_owner_e mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage carries no reset; stale entries are never observed past empty.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign cnt_o   = cnt_q;

endmodule : scr1_imem_arb_owner_fifo

// File: rtl/scr1_imem_arb.sv
// Core/aux arbiter in front of the single SCR1 imem port. Define
// SCR1_IMEM_ARB_RR_EN for round-robin arbitration; default is core priority.
module scr1_imem_arb
   import scr1_imem_arb_pkg::*;
#(
   parameter int OUTSTD_DEPTH = 4,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          core_imem_req,
   input  logic [ADDR_W-1:0]             core_imem_addr,
   output logic                          core_imem_req_ack,
   output logic [DATA_W-1:0]             core_imem_rdata,
   output logic [1:0]                    core_imem_resp,
   input  logic                          aux_imem_req,
   input  logic [ADDR_W-1:0]             aux_imem_addr,
   output logic                          aux_imem_req_ack,
   output logic [DATA_W-1:0]             aux_imem_rdata,
   output logic [1:0]                    aux_imem_resp,
   output logic                          imem_req,
   output logic [ADDR_W-1:0]             imem_addr,
   input  logic                          imem_req_ack,
   input  logic [DATA_W-1:0]             imem_rdata,
   input  logic [1:0]                    imem_resp,
   output logic [$clog2(OUTSTD_DEPTH):0] arb_pend_cnt,
   output logic                          arb_err
);

   type_scr1_imem_arb_owner_e sel;
   type_scr1_imem_arb_owner_e lock_sel_q;
   type_scr1_imem_arb_owner_e fifo_head;
   logic lock_q, lock_d;
   logic err_q, err_d;
   logic fifo_full, fifo_empty;
   logic accept, resp_vld, resp_route;
`ifdef SCR1_IMEM_ARB_RR_EN
   type_scr1_imem_arb_owner_e rr_q, rr_d;
`endif

   // A request offered but not yet acked keeps its owner on the bus.
   always_comb begin
      sel = CORE;
      if (lock_q) begin
         sel = lock_sel_q;
      end else if (core_imem_req & aux_imem_req) begin
`ifdef SCR1_IMEM_ARB_RR_EN
         sel = rr_q;
`else
         sel = CORE;
`endif
      end else if (aux_imem_req) begin
         sel = AUX;
      end
   end

   assign imem_req  = (core_imem_req | aux_imem_req) & ~fifo_full & ~rst;
   assign imem_addr = (sel == AUX) ? aux_imem_addr : core_imem_addr;
   assign accept    = imem_req & imem_req_ack;
   assign lock_d    = imem_req & ~imem_req_ack;

   assign core_imem_req_ack = accept & (sel == CORE);
   assign aux_imem_req_ack  = accept & (sel == AUX);

   assign resp_vld   = (imem_resp != SCR1_MEM_RESP_NOTRDY);
   assign resp_route = resp_vld & ~fifo_empty;
   assign err_d      = err_q | (resp_vld & fifo_empty);

   assign core_imem_resp  = (resp_route && fifo_head == CORE) ? imem_resp  : SCR1_MEM_RESP_NOTRDY;
   assign core_imem_rdata = (resp_route && fifo_head == CORE) ? imem_rdata : '0;
   assign aux_imem_resp   = (resp_route && fifo_head == AUX)  ? imem_resp  : SCR1_MEM_RESP_NOTRDY;
   assign aux_imem_rdata  = (resp_route && fifo_head == AUX)  ? imem_rdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q     <= 1'b0;
         lock_sel_q <= CORE;
         err_q      <= 1'b0;
      end else begin
         lock_q     <= lock_d;
         lock_sel_q <= sel;
         err_q      <= err_d;
      end
   end

`ifdef SCR1_IMEM_ARB_RR_EN
   assign rr_d = accept ? ((sel == CORE) ? AUX : CORE) : rr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_q <= CORE;
      else     rr_q <= rr_d;
   end
`endif

   scr1_imem_arb_owner_fifo #(
      .DEPTH (OUTSTD_DEPTH)
   ) u_owner_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (accept),
      .pop_i   (resp_route),
      .din_i   (sel),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .cnt_o   (arb_pend_cnt)
   );

   assign arb_err = err_q;

endmodule : scr1_imem_arb

// File: tb/tb_scr1_imem_arb.sv
// Bench for scr1_imem_arb: directed vector table, hand-written contention
// sequence and a randomized run against an owner-queue reference model.
module tb_scr1_imem_arb;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_imem_req, aux_imem_req;
   logic [31:0] core_imem_addr, aux_imem_addr;
   logic        core_imem_req_ack, aux_imem_req_ack;
   logic [31:0] core_imem_rdata, aux_imem_rdata;
   logic [1:0]  core_imem_resp, aux_imem_resp;
   logic        imem_req, imem_req_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic [1:0]  imem_resp;
   logic [2:0]  arb_pend_cnt;
   logic        arb_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   scr1_imem_arb #(
      .OUTSTD_DEPTH (DEPTH),
      .ADDR_W       (32),
      .DATA_W       (32)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .core_imem_req     (core_imem_req),
      .core_imem_addr    (core_imem_addr),
      .core_imem_req_ack (core_imem_req_ack),
      .core_imem_rdata   (core_imem_rdata),
      .core_imem_resp    (core_imem_resp),
      .aux_imem_req      (aux_imem_req),
      .aux_imem_addr     (aux_imem_addr),
      .aux_imem_req_ack  (aux_imem_req_ack),
      .aux_imem_rdata    (aux_imem_rdata),
      .aux_imem_resp     (aux_imem_resp),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_req_ack      (imem_req_ack),
      .imem_rdata        (imem_rdata),
      .imem_resp         (imem_resp),
      .arb_pend_cnt      (arb_pend_cnt),
      .arb_err           (arb_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic set_in(input logic cr, input logic ar, input logic [31:0] ca, input logic [31:0] aa,
                         input logic ack, input logic [1:0] rsp, input logic [31:0] rd);
      core_imem_req  = cr;
      aux_imem_req   = ar;
      core_imem_addr = ca;
      aux_imem_addr  = aa;
      imem_req_ack   = ack;
      imem_resp      = rsp;
      imem_rdata     = rd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_reset(input string tag);
      chk({tag, "_imem_req"}, 64'(imem_req), 64'd0);
      chk({tag, "_cack"},     64'(core_imem_req_ack), 64'd0);
      chk({tag, "_aack"},     64'(aux_imem_req_ack), 64'd0);
      chk({tag, "_cresp"},    64'(core_imem_resp), 64'd0);
      chk({tag, "_aresp"},    64'(aux_imem_resp), 64'd0);
      chk({tag, "_crdata"},   64'(core_imem_rdata), 64'd0);
      chk({tag, "_ardata"},   64'(aux_imem_rdata), 64'd0);
      chk({tag, "_cnt"},      64'(arb_pend_cnt), 64'd0);
      chk({tag, "_err"},      64'(arb_err), 64'd0);
   endtask

   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      #2;
      chk_idle_reset(tag);
      step();
      rst = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic cr, ar; logic [31:0] ca, aa; logic ack; logic [1:0] rsp; logic [31:0] rd;
      logic e_req; logic [31:0] e_addr; logic e_cack, e_aack;
      logic [1:0] e_cresp; logic [31:0] e_crd; logic [1:0] e_aresp; logic [31:0] e_ard;
      logic [2:0] e_cnt; logic e_err;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic cr, logic ar, logic [31:0] ca, logic [31:0] aa, logic ack,
                               logic [1:0] rsp, logic [31:0] rd, logic e_req, logic [31:0] e_addr,
                               logic e_cack, logic e_aack, logic [1:0] e_cresp, logic [31:0] e_crd,
                               logic [1:0] e_aresp, logic [31:0] e_ard, logic [2:0] e_cnt, logic e_err);
      vec_t v;
      v.cr = cr; v.ar = ar; v.ca = ca; v.aa = aa; v.ack = ack; v.rsp = rsp; v.rd = rd;
      v.e_req = e_req; v.e_addr = e_addr; v.e_cack = e_cack; v.e_aack = e_aack;
      v.e_cresp = e_cresp; v.e_crd = e_crd; v.e_aresp = e_aresp; v.e_ard = e_ard;
      v.e_cnt = e_cnt; v.e_err = e_err;
      return v;
   endfunction

   // ---------------- reference model ----------------
   bit mq[$];            // owners of accepted, unanswered transfers (0 core, 1 aux)
   bit m_err;
   bit m_hv, m_ho;       // an offered, unacked request and its owner
`ifdef SCR1_IMEM_ARB_RR_EN
   bit m_last_aux;       // owner of the most recent accepted transfer
`endif

   task automatic model_clear();
      mq.delete();
      m_err = 1'b0;
      m_hv  = 1'b0;
      m_ho  = 1'b0;
`ifdef SCR1_IMEM_ARB_RR_EN
      m_last_aux = 1'b1;  // so that core is favoured first after reset
`endif
   endtask

   task automatic model_cycle();
      bit full, ereq, g, acc;
      logic [1:0]  ecr, ear;
      logic [31:0] ecd, ead;
      full = (mq.size() == DEPTH);
      ereq = (core_imem_req || aux_imem_req) && !full;
      if (m_hv)
         g = m_ho;
      else if (core_imem_req && aux_imem_req)
`ifdef SCR1_IMEM_ARB_RR_EN
         g = !m_last_aux;
`else
         g = 1'b0;
`endif
      else
         g = aux_imem_req;
      acc = ereq && imem_req_ack;
      ecr = 2'b00; ear = 2'b00; ecd = '0; ead = '0;
      if (imem_resp != 2'b00 && mq.size() > 0) begin
         if (mq[0]) begin ear = imem_resp; ead = imem_rdata; end
         else       begin ecr = imem_resp; ecd = imem_rdata; end
      end
      chk("m_imem_req", 64'(imem_req), 64'(ereq));
      if (ereq) chk("m_imem_addr", 64'(imem_addr), 64'(g ? aux_imem_addr : core_imem_addr));
      chk("m_cack",   64'(core_imem_req_ack), 64'(acc && !g));
      chk("m_aack",   64'(aux_imem_req_ack),  64'(acc && g));
      chk("m_cresp",  64'(core_imem_resp), 64'(ecr));
      chk("m_crdata", 64'(core_imem_rdata), 64'(ecd));
      chk("m_aresp",  64'(aux_imem_resp), 64'(ear));
      chk("m_ardata", 64'(aux_imem_rdata), 64'(ead));
      chk("m_cnt",    64'(arb_pend_cnt), 64'(mq.size()));
      chk("m_err",    64'(arb_err), 64'(m_err));
      if (imem_resp != 2'b00) begin
         if (mq.size() == 0) m_err = 1'b1;
         else void'(mq.pop_front());
      end
      if (acc) begin
         mq.push_back(g);
`ifdef SCR1_IMEM_ARB_RR_EN
         m_last_aux = g;
`endif
      end
      m_hv = ereq && !imem_req_ack;
      m_ho = g;
   endtask

   initial begin
      bit exp_g [4];
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 2'b00, 0);
      #3;
      chk_idle_reset("reset");
      step();
      rst = 1'b0;

      // core fetch, lock, full, empty-response error
      vt.push_back(mk(1,0,32'h200,0,1,0,0,                1,32'h200,1,0,0,0,0,0,0,0));
      vt.push_back(mk(0,0,0,0,0,0,0,                      0,0,0,0,0,0,0,0,1,0));
      vt.push_back(mk(0,0,0,0,0,2'b01,32'h00100093,       0,0,0,0,2'b01,32'h00100093,0,0,1,0));
      vt.push_back(mk(0,0,0,0,0,0,0,                      0,0,0,0,0,0,0,0,0,0));
      vt.push_back(mk(0,1,32'h400,32'h300,0,0,0,          1,32'h300,0,0,0,0,0,0,0,0));
      vt.push_back(mk(1,1,32'h400,32'h300,0,0,0,          1,32'h300,0,0,0,0,0,0,0,0));
      vt.push_back(mk(1,1,32'h400,32'h300,0,0,0,          1,32'h300,0,0,0,0,0,0,0,0));
      vt.push_back(mk(1,1,32'h400,32'h300,1,0,0,          1,32'h300,0,1,0,0,0,0,0,0));
      vt.push_back(mk(1,0,32'h400,0,1,0,0,                1,32'h400,1,0,0,0,0,0,1,0));
      vt.push_back(mk(0,0,0,0,0,2'b10,32'hBAD,            0,0,0,0,0,0,2'b10,32'hBAD,2,0));
      vt.push_back(mk(0,0,0,0,0,2'b01,32'h1234,           0,0,0,0,2'b01,32'h1234,0,0,1,0));
      vt.push_back(mk(0,0,0,0,0,0,0,                      0,0,0,0,0,0,0,0,0,0));
      for (int i = 0; i < 4; i++)
         vt.push_back(mk(1,0,32'h1000+32'(4*i),0,1,0,0,   1,32'h1000+32'(4*i),1,0,0,0,0,0,3'(i),0));
      vt.push_back(mk(1,0,32'h2000,0,1,0,0,               0,0,0,0,0,0,0,0,4,0));
      vt.push_back(mk(1,0,32'h2000,0,1,2'b10,32'h55,      0,0,0,0,2'b10,32'h55,0,0,4,0));
      vt.push_back(mk(1,0,32'h2000,0,0,0,0,               1,32'h2000,0,0,0,0,0,0,3,0));
      for (int i = 0; i < 3; i++)
         vt.push_back(mk(0,0,0,0,0,2'b01,32'(i+1),        0,0,0,0,2'b01,32'(i+1),0,0,3'(3-i),0));
      vt.push_back(mk(0,0,0,0,0,0,0,                      0,0,0,0,0,0,0,0,0,0));
      vt.push_back(mk(0,0,0,0,0,2'b01,32'h77,             0,0,0,0,0,0,0,0,0,0));
      vt.push_back(mk(0,0,0,0,0,0,0,                      0,0,0,0,0,0,0,0,0,1));
      vt.push_back(mk(0,0,0,0,0,0,0,                      0,0,0,0,0,0,0,0,0,1));

      for (int i = 0; i < vt.size(); i++) begin
         set_in(vt[i].cr, vt[i].ar, vt[i].ca, vt[i].aa, vt[i].ack, vt[i].rsp, vt[i].rd);
         #2;
         chk($sformatf("v%0d_imem_req", i), 64'(imem_req), 64'(vt[i].e_req));
         if (vt[i].e_req) chk($sformatf("v%0d_imem_addr", i), 64'(imem_addr), 64'(vt[i].e_addr));
         chk($sformatf("v%0d_cack", i),   64'(core_imem_req_ack), 64'(vt[i].e_cack));
         chk($sformatf("v%0d_aack", i),   64'(aux_imem_req_ack),  64'(vt[i].e_aack));
         chk($sformatf("v%0d_cresp", i),  64'(core_imem_resp),  64'(vt[i].e_cresp));
         chk($sformatf("v%0d_crdata", i), 64'(core_imem_rdata), 64'(vt[i].e_crd));
         chk($sformatf("v%0d_aresp", i),  64'(aux_imem_resp),   64'(vt[i].e_aresp));
         chk($sformatf("v%0d_ardata", i), 64'(aux_imem_rdata),  64'(vt[i].e_ard));
         chk($sformatf("v%0d_cnt", i),    64'(arb_pend_cnt), 64'(vt[i].e_cnt));
         chk($sformatf("v%0d_err", i),    64'(arb_err), 64'(vt[i].e_err));
         step();
      end

      // sticky error cleared by a reset pulse
      set_in(1, 1, 32'h10, 32'h20, 1, 2'b01, 32'h99);
      pulse_reset("rst_err");
      set_in(0, 0, 0, 0, 0, 2'b00, 0);
      #2;
      chk("post_rst_err", 64'(arb_err), 64'd0);
      chk("post_rst_cnt", 64'(arb_pend_cnt), 64'd0);
      step();

      // contention: both request every cycle until the owner FIFO fills
      for (int i = 0; i < 4; i++)
`ifdef SCR1_IMEM_ARB_RR_EN
         exp_g[i] = (i % 2 == 1);
`else
         exp_g[i] = 1'b0;
`endif
      for (int i = 0; i < 4; i++) begin
         set_in(1, 1, 32'hC000_0000 + 32'(i), 32'hA000_0000 + 32'(i), 1, 2'b00, 0);
         #2;
         chk($sformatf("ct%0d_req", i), 64'(imem_req), 64'd1);
         chk($sformatf("ct%0d_addr", i), 64'(imem_addr),
             64'(exp_g[i] ? 32'hA000_0000 + 32'(i) : 32'hC000_0000 + 32'(i)));
         chk($sformatf("ct%0d_cack", i), 64'(core_imem_req_ack), 64'(!exp_g[i]));
         chk($sformatf("ct%0d_aack", i), 64'(aux_imem_req_ack),  64'(exp_g[i]));
         step();
      end
      set_in(0, 1, 0, 32'hA000_0010, 1, 2'b00, 0);
      #2;
      chk("ct_full_req", 64'(imem_req), 64'd0);
      chk("ct_full_cnt", 64'(arb_pend_cnt), 64'd4);
      step();
      for (int i = 0; i < 4; i++) begin
         set_in(0, 0, 0, 0, 0, 2'b01, 32'hD0 + 32'(i));
         #2;
         chk($sformatf("ct%0d_cresp", i), 64'(core_imem_resp), 64'(exp_g[i] ? 2'b00 : 2'b01));
         chk($sformatf("ct%0d_aresp", i), 64'(aux_imem_resp),  64'(exp_g[i] ? 2'b01 : 2'b00));
         chk($sformatf("ct%0d_rdata", i), 64'(exp_g[i] ? aux_imem_rdata : core_imem_rdata),
             64'(32'hD0 + 32'(i)));
         step();
      end
      set_in(0, 1, 0, 32'hA000_0020, 1, 2'b00, 0);
      #2;
      chk("ct_aux_alone_ack", 64'(aux_imem_req_ack), 64'd1);
      step();
      pulse_reset("rst_ct");

      // randomized traffic against the reference model
      model_clear();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [1:0] rsp;
         rsp = 2'b00;
         if (mq.size() > 0 && $urandom_range(0, 99) < 45)
            rsp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01;
         else if ($urandom_range(0, 999) < 3)
            rsp = 2'b01;
         set_in(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 60), $urandom, $urandom,
                1'($urandom_range(0, 99) < 55), rsp, $urandom);
         if ($urandom_range(0, 499) == 0) begin
            pulse_reset("rst_rand");
            model_clear();
         end else begin
            #2;
            model_cycle();
            step();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_scr1_imem_arb
